// File: rtl/cpu16_ctrl_pkg.sv
// Shared encodings for the 16-bit multi-cycle CPU control path.
package cpu16_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_EXEC_R   = 4'd3,
      ST_WB_R     = 4'd4,
      ST_EXEC_I   = 4'd5,
      ST_WB_I     = 4'd6,
      ST_MEM_ADDR = 4'd7,
      ST_MEM_RD   = 4'd8,
      ST_WB_MEM   = 4'd9,
      ST_MEM_WR   = 4'd10,
      ST_BRANCH   = 4'd11,
      ST_JUMP     = 4'd12,
      ST_TRAP     = 4'd13
   } state_t;

   localparam logic [3:0] OP_R0  = 4'b0000;
   localparam logic [3:0] OP_R1  = 4'b0001;
   localparam logic [3:0] OP_R2  = 4'b0010;
   localparam logic [3:0] OP_I0  = 4'b1001;
   localparam logic [3:0] OP_I1  = 4'b1010;
   localparam logic [3:0] OP_I2  = 4'b1011;
   localparam logic [3:0] OP_LW  = 4'b1100;
   localparam logic [3:0] OP_SW  = 4'b1101;
   localparam logic [3:0] OP_JMP = 4'b1110;
   localparam logic [3:0] OP_BEQ = 4'b1111;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

   localparam logic [1:0] SRC_B_REG = 2'b00;
   localparam logic [1:0] SRC_B_ONE = 2'b01;
   localparam logic [1:0] SRC_B_IMM = 2'b10;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] TRAP_NONE    = 2'b00;
   localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
   localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

   // States that wait on the memory handshake.
   function automatic logic is_mem_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Saturating count of consecutive memory wait cycles with timeout compare.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   logic [CNT_W-1:0] cnt;

   // Clear has priority; increment saturates at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // A zero limit disables the timeout entirely.
   assign expired = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer driving the 16-bit CPU datapath controls.
module multicycle_ctrl
   import cpu16_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [3:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       instr_done,
   output logic       trap,
   output logic [1:0] trap_cause
);

   state_t     state, next_state;
   logic [1:0] cause_next;
   logic       expired;
   logic       tmr_clear, tmr_inc;

   // Counter restarts whenever a state is entered or the memory answers.
   assign tmr_clear = (next_state != state) || mem_ready;
   assign tmr_inc   = is_mem_state(state) && !mem_ready;

   mem_wait_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tmr_clear),
      .inc     (tmr_inc),
      .expired (expired)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Trap cause latched on entry to TRAP and held until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_cause <= TRAP_NONE;
      end else if ((next_state == ST_TRAP) && (state != ST_TRAP)) begin
         trap_cause <= cause_next;
      end
   end

   // Next-state and per-state control decode.
   always_comb begin
      next_state    = state;
      cause_next    = TRAP_NONE;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRC_B_REG;
      alu_op        = ALU_OP_ADD;
      pc_src        = PC_SRC_ALU;
      instr_done    = 1'b0;
      trap          = 1'b0;

      case (state)
         ST_IDLE: begin
            if (run) next_state = ST_FETCH;
         end
         ST_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRC_B_ONE;
            pc_write  = mem_ready;
            ir_write  = mem_ready;
            if (mem_ready) begin
               next_state = ST_DECODE;
            end else if (expired) begin
               next_state = ST_TRAP;
               cause_next = TRAP_TIMEOUT;
            end
         end
         ST_DECODE: begin
            alu_src_b = SRC_B_IMM;
            case (opcode)
               OP_R0, OP_R1, OP_R2: next_state = ST_EXEC_R;
               OP_I0, OP_I1, OP_I2: next_state = ST_EXEC_I;
               OP_LW, OP_SW:        next_state = ST_MEM_ADDR;
               OP_BEQ:              next_state = ST_BRANCH;
               OP_JMP:              next_state = ST_JUMP;
               default: begin
                  next_state = ST_TRAP;
                  cause_next = TRAP_ILLEGAL;
               end
            endcase
         end
         ST_EXEC_R: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRC_B_REG;
            alu_op     = ALU_OP_FUNCT;
            next_state = ST_WB_R;
         end
         ST_WB_R: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            next_state = run ? ST_FETCH : ST_IDLE;
         end
         ST_EXEC_I: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRC_B_IMM;
            alu_op     = ALU_OP_ITYPE;
            next_state = ST_WB_I;
         end
         ST_WB_I: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            next_state = run ? ST_FETCH : ST_IDLE;
         end
         ST_MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRC_B_IMM;
            next_state = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
         end
         ST_MEM_RD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) begin
               next_state = ST_WB_MEM;
            end else if (expired) begin
               next_state = ST_TRAP;
               cause_next = TRAP_TIMEOUT;
            end
         end
         ST_WB_MEM: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            next_state = run ? ST_FETCH : ST_IDLE;
         end
         ST_MEM_WR: begin
            iord       = 1'b1;
            mem_write  = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) begin
               next_state = run ? ST_FETCH : ST_IDLE;
            end else if (expired) begin
               next_state = ST_TRAP;
               cause_next = TRAP_TIMEOUT;
            end
         end
         ST_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRC_B_REG;
            alu_op        = ALU_OP_SUB;
            pc_write_cond = 1'b1;
            pc_src        = PC_SRC_ALUOUT;
            instr_done    = 1'b1;
            next_state    = run ? ST_FETCH : ST_IDLE;
         end
         ST_JUMP: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JUMP;
            instr_done = 1'b1;
            next_state = run ? ST_FETCH : ST_IDLE;
         end
         ST_TRAP: begin
            trap = 1'b1;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

endmodule
